// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC sample capture slice: FSM states,
// SRAM bank geometry, channel tag width and the bank select helper.
package adc_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cap_state_t;

   localparam int NUM_BANKS = 4;
   localparam int BANK_AW   = 9;
   localparam int CH_ID_W   = 2;
   localparam logic [NUM_BANKS-1:0] WMASK_ALL = 4'hF;

   // Active-low one-cold select for the bank addressed by the upper pointer bits.
   function automatic logic [NUM_BANKS-1:0] bank_sel_n(input logic [1:0] bank);
      bank_sel_n = ~(NUM_BANKS'(1) << bank);
   endfunction

endpackage

// File: rtl/adc_sample_capture_arbiter.sv
// Round-robin arbiter: one-hot grant among requesting channels, priority
// rotating past the last granted channel; clr restores channel 0 as first.
module rr_arbiter
   import adc_capture_pkg::*;
#(
   parameter int NUM_CH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic [NUM_CH-1:0]  req,
   output logic [NUM_CH-1:0]  grant,
   output logic [CH_ID_W-1:0] grant_idx
);

   localparam logic [CH_ID_W-1:0] LAST_CH = CH_ID_W'(NUM_CH - 1);

   logic [CH_ID_W-1:0] last_q;
   logic               found;
   int                 idx;

   // Search starts one past the previous winner so every requester is served in turn.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(last_q) + i) % NUM_CH;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = CH_ID_W'(idx);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= LAST_CH;
      end else if (clr) begin
         last_q <= LAST_CH;
      end else if (found) begin
         last_q <= grant_idx;
      end
   end

endmodule

// File: rtl/adc_sample_capture.sv
// Captures decimated ADC samples into four 512-word SRAM banks as one linear buffer.
// Optional SAMPLE_TAG_EN: replaces data bits [31:30] with the source channel index.
module adc_sample_capture
   import adc_capture_pkg::*;
#(
   parameter int NUM_CH    = 3,
   parameter int DW        = 32,
   parameter int DEPTH_LG2 = 11
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [NUM_CH-1:0]    chan_en_i,
   input  logic [DEPTH_LG2-1:0] num_samples_i,
   input  logic [NUM_CH-1:0]    adc_dvalid_i,
   input  logic [DW-1:0]        adc0_dat_i,
   input  logic [DW-1:0]        adc1_dat_i,
   input  logic [DW-1:0]        adc2_dat_i,
   output logic [NUM_BANKS-1:0] mem_wenb_o,
   output logic [BANK_AW-1:0]   mem_waddr_o,
   output logic [DW-1:0]        mem_data_o,
   output logic [NUM_BANKS-1:0] wmask_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 irq_o,
   output logic                 overflow_o,
   output logic [DEPTH_LG2:0]   wr_count_o
);

   localparam int CNT_W = DEPTH_LG2 + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << DEPTH_LG2;

   cap_state_t           state_q, state_d;
   logic                 enter_run, issue, to_done;
   logic [DEPTH_LG2-1:0] ptr_q;
   logic [CNT_W-1:0]     count_q, target_q;
   logic [NUM_CH-1:0]    chan_en_q, pend_q, capture, grant;
   logic [CH_ID_W-1:0]   grant_idx;
   logic [DW-1:0]        adc_dat [3];
   logic [DW-1:0]        hold_q [NUM_CH];
   logic [DW-1:0]        wr_data;
   logic                 overflow_q, irq_q;

   assign adc_dat[0] = adc0_dat_i;
   assign adc_dat[1] = adc1_dat_i;
   assign adc_dat[2] = adc2_dat_i;

   // Abort overrides everything, including a start in the same cycle.
   always_comb begin
      state_d   = state_q;
      enter_run = 1'b0;
      issue     = 1'b0;
      to_done   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d   = ST_RUN;
               enter_run = 1'b1;
            end
         end
         ST_RUN: begin
            if (count_q == target_q) begin
               state_d = ST_DONE;
               to_done = 1'b1;
            end else begin
               issue = |pend_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort_i) begin
         state_d   = ST_IDLE;
         enter_run = 1'b0;
         issue     = 1'b0;
         to_done   = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_n_i),
      .clr       (enter_run),
      .en        (issue),
      .req       (pend_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign capture = adc_dvalid_i & chan_en_q & {NUM_CH{(state_q == ST_RUN) && !abort_i}};

`ifdef SAMPLE_TAG_EN
   assign wr_data = {grant_idx, hold_q[grant_idx][DW-CH_ID_W-1:0]};
`else
   assign wr_data = hold_q[grant_idx];
`endif

   // A channel being granted this cycle can accept a fresh sample; otherwise it is lost.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         pend_q     <= '0;
         overflow_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_q[k] <= '0;
         end
      end else begin
         if (enter_run) begin
            overflow_q <= 1'b0;
         end
         for (int k = 0; k < NUM_CH; k++) begin
            if (state_q != ST_RUN) begin
               pend_q[k] <= 1'b0;
            end else if (capture[k]) begin
               if (!pend_q[k] || grant[k]) begin
                  hold_q[k] <= adc_dat[k];
                  pend_q[k] <= 1'b1;
               end else begin
                  overflow_q <= 1'b1;
               end
            end else if (grant[k]) begin
               pend_q[k] <= 1'b0;
            end
         end
      end
   end

   // SRAM port is fully registered; a select is held for exactly one cycle per word.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         mem_wenb_o  <= WMASK_ALL;
         mem_waddr_o <= '0;
         mem_data_o  <= '0;
         ptr_q       <= '0;
         count_q     <= '0;
         target_q    <= FULL_CNT;
         chan_en_q   <= '0;
         irq_q       <= 1'b0;
      end else begin
         irq_q      <= to_done;
         mem_wenb_o <= WMASK_ALL;
         if (enter_run) begin
            ptr_q     <= '0;
            count_q   <= '0;
            chan_en_q <= chan_en_i;
            target_q  <= (num_samples_i == '0) ? FULL_CNT : {1'b0, num_samples_i};
         end else if (issue) begin
            mem_wenb_o  <= bank_sel_n(ptr_q[DEPTH_LG2-1:BANK_AW]);
            mem_waddr_o <= ptr_q[BANK_AW-1:0];
            mem_data_o  <= wr_data;
            ptr_q       <= ptr_q + 1'b1;
            count_q     <= count_q + 1'b1;
         end
      end
   end

   assign busy_o     = (state_q == ST_RUN);
   assign done_o     = (state_q == ST_DONE);
   assign irq_o      = irq_q;
   assign overflow_o = overflow_q;
   assign wr_count_o = count_q;
   assign wmask_o    = WMASK_ALL;

endmodule
